perf_counter_bank: RTL



---
 rtl/perf_cnt_pkg.sv | 25 ++
 rtl/perf_counter.sv | 50 +++++
 rtl/perf_counter_bank.sv | 115 +++++++++++
 3 files changed

// File: rtl/perf_cnt_pkg.sv
// Shared definitions for the performance counter bank: channel indices
// used by the mp4 pipeline, the default per-channel increment type and a
// helper that sizes the read-select port.
package perf_cnt_pkg;

  // Channel assignment used by the pipeline event taps.
  localparam int CNT_BR        = 0;
  localparam int CNT_BR_MISP   = 1;
  localparam int CNT_JAL       = 2;
  localparam int CNT_JAL_MISP  = 3;
  localparam int CNT_JALR      = 4;
  localparam int CNT_JALR_MISP = 5;
  localparam int CNT_COMMIT    = 6;
  localparam int CNT_STALL     = 7;

  // Default increment width: up to 3 events per channel per cycle.
  localparam int PERF_INC_WIDTH = 2;
  typedef logic [PERF_INC_WIDTH-1:0] perf_inc_t;

  // Read-select width: clog2 of the channel count, never below one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// One counter channel: CNT_WIDTH+1 bit adder, wrap or saturate on carry
// out, and a sticky overflow flag. Clear has priority over counting.
module perf_counter #(
  parameter int CNT_WIDTH = 32,
  parameter int INC_WIDTH = 2,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cnt_en,
  input  logic                 clear,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 ovf
);

  logic [CNT_WIDTH:0]   sum;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 ovf_next;

  // Next counter value and flag; the carry out of the top bit is the overflow.
  always_comb begin
    cnt_next = cnt;
    ovf_next = ovf;
    sum      = {1'b0, cnt} + {{(CNT_WIDTH + 1 - INC_WIDTH){1'b0}}, inc};
    if (clear) begin
      cnt_next = '0;
      ovf_next = 1'b0;
    end else if (cnt_en) begin
      if (sum[CNT_WIDTH]) begin
        ovf_next = 1'b1;
        cnt_next = (SATURATE != 0) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
      end else begin
        cnt_next = sum[CNT_WIDTH-1:0];
      end
    end
  end

  // Counter and sticky flag state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT event counters with a registered read port.
// Optional feature macro: PERF_CNT_SNAPSHOT_EN adds snap_i and shadow
// registers; reads then return the shadow copy instead of the live counters.
module perf_counter_bank
  import perf_cnt_pkg::*;
#(
  parameter int NUM_CNT   = 8,
  parameter int CNT_WIDTH = 32,
  parameter int INC_WIDTH = 2,
  parameter int SATURATE  = 0,
  localparam int SEL_W    = sel_width(NUM_CNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cnt_en_i,
  input  logic [NUM_CNT*INC_WIDTH-1:0] inc_i,
  input  logic                         clear_i,
`ifdef PERF_CNT_SNAPSHOT_EN
  input  logic                         snap_i,
`endif
  input  logic                         rd_req_i,
  input  logic [SEL_W-1:0]             rd_sel_i,
  output logic                         rd_valid_o,
  output logic [CNT_WIDTH-1:0]         rd_data_o,
  output logic                         rd_ovf_o,
  output logic [NUM_CNT-1:0]           ovf_o
);

  // Selects beyond NUM_CNT map onto zero entries of a power-of-two table.
  localparam int SEL_N = 1 << SEL_W;

  logic [CNT_WIDTH-1:0] live_cnt [NUM_CNT];
  logic [CNT_WIDTH-1:0] src_cnt  [NUM_CNT];
  logic [NUM_CNT-1:0]   src_ovf;
  logic [CNT_WIDTH-1:0] rd_tab   [SEL_N];
  logic [SEL_N-1:0]     rd_tab_ovf;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_chan
      perf_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .INC_WIDTH (INC_WIDTH),
        .SATURATE  (SATURATE)
      ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .cnt_en (cnt_en_i),
        .clear  (clear_i),
        .inc    (inc_i[gi*INC_WIDTH +: INC_WIDTH]),
        .cnt    (live_cnt[gi]),
        .ovf    (ovf_o[gi])
      );
    end
  endgenerate

`ifdef PERF_CNT_SNAPSHOT_EN
  logic [CNT_WIDTH-1:0] shadow_cnt [NUM_CNT];
  logic [NUM_CNT-1:0]   shadow_ovf;

  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_shadow
      // Shadow copy takes the pre-update live value, so a snap alongside
      // clear still captures what was counted before the clear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_cnt[gi] <= '0;
          shadow_ovf[gi] <= 1'b0;
        end else if (snap_i) begin
          shadow_cnt[gi] <= live_cnt[gi];
          shadow_ovf[gi] <= ovf_o[gi];
        end
      end
      assign src_cnt[gi] = shadow_cnt[gi];
      assign src_ovf[gi] = shadow_ovf[gi];
    end
  endgenerate
`else
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_src
      assign src_cnt[gi] = live_cnt[gi];
      assign src_ovf[gi] = ovf_o[gi];
    end
  endgenerate
`endif

  generate
    for (gi = 0; gi < SEL_N; gi++) begin : g_tab
      if (gi < NUM_CNT) begin : g_used
        assign rd_tab[gi]     = src_cnt[gi];
        assign rd_tab_ovf[gi] = src_ovf[gi];
      end else begin : g_unused
        assign rd_tab[gi]     = '0;
        assign rd_tab_ovf[gi] = 1'b0;
      end
    end
  endgenerate

  // Read register: samples pre-edge values, data holds between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      rd_ovf_o   <= 1'b0;
    end else begin
      rd_valid_o <= rd_req_i;
      if (rd_req_i) begin
        rd_data_o <= rd_tab[rd_sel_i];
        rd_ovf_o  <= rd_tab_ovf[rd_sel_i];
      end
    end
  end

endmodule
